// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
// Word-addressed req/ack data-memory port between the MEM-stage access
// controller (master) and the data memory (slave).
//   mem_req   master->slave  request, held until ack or abort
//   mem_we    master->slave  1 = write, 0 = read
//   mem_addr  master->slave  word address (byte address [31:2])
//   mem_wdata master->slave  lane-replicated store data
//   mem_be    master->slave  byte enables
//   mem_rdata slave->master  read word
//   mem_ack   slave->master  completion, one-cycle pulse
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory access controller. Decodes the EX/MEM memory-control
// fields, issues one word-addressed req/ack transaction per valid aligned op,
// stalls the pipeline through busywait and returns the extended load word.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   mem_read_in      [3]=load enable, [2:0]=funct3
//   mem_write_in     [2]=store enable, [1:0]=size (00 B, 01 H, 10 W)
//   addr_in          byte address
//   store_data_in    store operand
//   busywait         stall request (combinational)
//   load_data_out    extended load result (held between loads)
//   misaligned_out   current op is misaligned (combinational)
//   bus_error_out    set for the DONE cycle after an ack timeout
//   bus              memory port (mem_access_unit_if.master)
// Parameter ACK_TIMEOUT: ACCESS cycles without ack before abort, 0 = never.
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        mem_read_in,
    input  logic [2:0]        mem_write_in,
    input  logic [31:0]       addr_in,
    input  logic [31:0]       store_data_in,
    output logic              busywait,
    output logic [31:0]       load_data_out,
    output logic              misaligned_out,
    output logic              bus_error_out,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] cnt_r;
    logic [1:0]  addr_lo_r;
    logic [1:0]  ld_size_r;
    logic        ld_unsigned_r;
    logic        is_load_r;

    logic        load_ok_s;
    logic        store_ok_s;
    logic        op_valid_s;
    logic [1:0]  size_s;
    logic        misaligned_s;
    logic        start_s;
    logic        timeout_s;
    logic        busy_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    // Picks the addressed byte/half out of the read word and extends it.
    function automatic logic [31:0] extend_load(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Load decode: only the five RV32 load funct3 codes are legal.
    always_comb begin
        load_ok_s = 1'b0;
        case (mem_read_in[2:0])
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: load_ok_s = mem_read_in[3];
            default:                                load_ok_s = 1'b0;
        endcase
    end

    assign store_ok_s = mem_write_in[2] && (mem_write_in[1:0] != 2'b11);
    assign op_valid_s = load_ok_s || store_ok_s;
    // A load takes priority, so its size governs alignment when both are set.
    assign size_s     = load_ok_s ? mem_read_in[1:0] : mem_write_in[1:0];

    // Alignment check on the effective access size.
    always_comb begin
        misaligned_s = 1'b0;
        if (op_valid_s) begin
            case (size_s)
                2'b01:   misaligned_s = addr_in[0];
                2'b10:   misaligned_s = (addr_in[1:0] != 2'b00);
                default: misaligned_s = 1'b0;
            endcase
        end else begin
            misaligned_s = 1'b0;
        end
    end

    assign start_s        = op_valid_s && !misaligned_s;
    assign misaligned_out = misaligned_s;
    assign timeout_s      = (ACK_TIMEOUT != 0) && (cnt_r == 32'(ACK_TIMEOUT - 1));

    // Store lane steering; loads always read the full word.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = 32'd0;
        if (load_ok_s) begin
            be_s    = 4'b1111;
            wdata_s = 32'd0;
        end else begin
            case (mem_write_in[1:0])
                2'b00: begin
                    be_s    = 4'b0001 << addr_in[1:0];
                    wdata_s = {4{store_data_in[7:0]}};
                end
                2'b01: begin
                    be_s    = 4'b0011 << addr_in[1:0];
                    wdata_s = {2{store_data_in[15:0]}};
                end
                default: begin
                    be_s    = 4'b1111;
                    wdata_s = store_data_in;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state and stall request; ack wins over a same-cycle timeout.
    always_comb begin
        state_next_s = state_r;
        busy_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = start_s;
                if (start_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                busy_s = 1'b1;
                if (bus.mem_ack || timeout_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_DONE: begin
                // Stall drops so EX/MEM advances; the op still visible is not re-issued.
                busy_s       = 1'b0;
                state_next_s = ST_IDLE;
            end
            default: begin
                busy_s       = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held so the pipeline is released at once.
    assign busywait = busy_s && !rst;

    // Memory port, timeout counter and load result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= 30'd0;
            bus.mem_wdata <= 32'd0;
            bus.mem_be    <= 4'd0;
            cnt_r         <= 32'd0;
            addr_lo_r     <= 2'd0;
            ld_size_r     <= 2'd0;
            ld_unsigned_r <= 1'b0;
            is_load_r     <= 1'b0;
            load_data_out <= 32'd0;
            bus_error_out <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= !load_ok_s;
                        bus.mem_addr  <= addr_in[31:2];
                        bus.mem_wdata <= wdata_s;
                        bus.mem_be    <= be_s;
                        cnt_r         <= 32'd0;
                        addr_lo_r     <= addr_in[1:0];
                        ld_size_r     <= mem_read_in[1:0];
                        ld_unsigned_r <= mem_read_in[2];
                        is_load_r     <= load_ok_s;
                    end
                end
                ST_ACCESS: begin
                    cnt_r <= cnt_r + 32'd1;
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        if (is_load_r) begin
                            load_data_out <= extend_load(bus.mem_rdata, addr_lo_r,
                                                         ld_size_r, ld_unsigned_r);
                        end
                    end else if (timeout_s) begin
                        bus.mem_req   <= 1'b0;
                        load_data_out <= 32'd0;
                        bus_error_out <= 1'b1;
                    end
                end
                ST_DONE: begin
                    bus_error_out <= 1'b0;
                end
                default: begin
                    bus.mem_req   <= 1'b0;
                    bus_error_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Randomized and directed stimulus for mem_access_unit (ACK_TIMEOUT = 4).
// A transaction-level model computes, for each op, the cycle-by-cycle
// busywait / mem_req / flag timeline and the bus fields and load result from
// the access rules; one negedge process compares the DUT against it.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  mem_read_in;
    logic [2:0]  mem_write_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        busywait;
    logic [31:0] load_data_out;
    logic        misaligned_out;
    logic        bus_error_out;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.ACK_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .addr_in       (addr_in),
        .store_data_in (store_data_in),
        .busywait      (busywait),
        .load_data_out (load_data_out),
        .misaligned_out(misaligned_out),
        .bus_error_out (bus_error_out),
        .bus           (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle values produced by the model
    logic        chk_en = 1'b0;
    logic        e_busy, e_req, e_mis, e_berr, e_we, e_chk_wdata;
    logic [29:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] ld_model;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Extended load value: bytes of the read word assembled from the access rules.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [7:0]  b [4];
        logic [31:0] v;
        int lo, nb;
        for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
        lo = int'(addr[1:0]);
        nb = 1 << f3[1:0];
        v  = 32'd0;
        for (int i = nb - 1; i >= 0; i--) v = (v << 8) | {24'd0, b[lo + i]};
        if (!f3[2] && nb < 4 && v[8*nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busywait",   {31'd0, busywait},       {31'd0, e_busy});
            check("mem_req",    {31'd0, bus_if.mem_req}, {31'd0, e_req});
            check("misaligned", {31'd0, misaligned_out}, {31'd0, e_mis});
            check("bus_error",  {31'd0, bus_error_out},  {31'd0, e_berr});
            check("load_data",  load_data_out,           ld_model);
            if (e_req) begin
                check("mem_addr", {2'd0, bus_if.mem_addr}, {2'd0, e_addr});
                check("mem_we",   {31'd0, bus_if.mem_we},  {31'd0, e_we});
                check("mem_be",   {28'd0, bus_if.mem_be},  {28'd0, e_be});
                if (e_chk_wdata) check("mem_wdata", bus_if.mem_wdata, e_wdata);
            end
        end
    end

    // Presents one op until it leaves the stage; ack arrives in ACCESS cycle n
    // (n > T means the unit times out first). One idle cycle follows.
    task automatic do_op(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                         input logic [31:0] sd, input int n, input logic [31:0] rdata,
                         input logic stray);
        logic ld_ok, st_ok, valid, mis;
        int   nb, lo, m;
        ld_ok = rd[3] && (rd[2:0] inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        st_ok = wr[2] && (wr[1:0] != 2'b11);
        valid = ld_ok || st_ok;
        nb    = ld_ok ? (1 << rd[1:0]) : (1 << wr[1:0]);
        lo    = int'(addr[1:0]);
        mis   = valid && ((lo % nb) != 0);

        mem_read_in   = rd;
        mem_write_in  = wr;
        addr_in       = addr;
        store_data_in = sd;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = $urandom;
        e_berr = 1'b0;
        e_req  = 1'b0;
        if (!valid || mis) begin
            e_busy = 1'b0;
            e_mis  = mis;
            for (int k = 0; k < 2; k++) begin
                @(posedge clk); #1;
            end
        end else begin
            m           = (n <= T) ? n : T;
            e_mis       = 1'b0;
            e_addr      = addr[31:2];
            e_we        = !ld_ok;
            e_chk_wdata = !ld_ok;
            e_be        = ld_ok ? 4'hF : 4'(((1 << nb) - 1) << lo);
            e_wdata     = (nb == 1) ? {4{sd[7:0]}} : (nb == 2) ? {2{sd[15:0]}} : sd;
            for (int k = 0; k <= m + 1; k++) begin
                if (k == m + 1) begin
                    if (n > T) ld_model = 32'd0;
                    else if (ld_ok) ld_model = model_load(rd[2:0], addr, rdata);
                end
                e_busy = (k <= m);
                e_req  = (k >= 1) && (k <= m);
                e_berr = (k == m + 1) && (n > T);
                bus_if.mem_ack   = (k == n);
                bus_if.mem_rdata = (k == n) ? rdata : $urandom;
                @(posedge clk); #1;
            end
        end
        mem_read_in   = 4'd0;
        mem_write_in  = 3'd0;
        addr_in       = $urandom;
        store_data_in = $urandom;
        e_busy = 1'b0;
        e_req  = 1'b0;
        e_mis  = 1'b0;
        e_berr = 1'b0;
        bus_if.mem_ack   = stray;
        bus_if.mem_rdata = $urandom;
        @(posedge clk); #1;
        bus_if.mem_ack = 1'b0;
    endtask

    // LW left waiting for ack, then reset asserted inside ACCESS cycle 2.
    task automatic reset_mid_access();
        mem_read_in   = 4'b1010;
        mem_write_in  = 3'd0;
        addr_in       = 32'h0000_0200;
        bus_if.mem_ack = 1'b0;
        e_busy = 1'b1; e_req = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
        e_addr = 30'h80; e_we = 1'b0; e_be = 4'hF; e_chk_wdata = 1'b0;
        @(posedge clk); #1;
        e_req = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mem_req",   {31'd0, bus_if.mem_req}, 32'd0);
        check("rst_busywait",  {31'd0, busywait},       32'd0);
        check("rst_load_data", load_data_out,           32'd0);
        check("rst_bus_error", {31'd0, bus_error_out},  32'd0);
        check("rst_mem_be",    {28'd0, bus_if.mem_be},  32'd0);
        ld_model    = 32'd0;
        mem_read_in = 4'd0;
        rst         = 1'b0;
        e_busy = 1'b0; e_req = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        mem_read_in = 4'd0; mem_write_in = 3'd0; addr_in = 32'd0; store_data_in = 32'd0;
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'd0;
        ld_model = 32'd0;
        e_busy = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
        e_we = 1'b0; e_chk_wdata = 1'b0; e_addr = 30'd0; e_be = 4'd0; e_wdata = 32'd0;
        #3;
        check("reset_load_data", load_data_out,              32'd0);
        check("reset_bus_error", {31'd0, bus_error_out},     32'd0);
        check("reset_mem_req",   {31'd0, bus_if.mem_req},    32'd0);
        check("reset_mem_we",    {31'd0, bus_if.mem_we},     32'd0);
        check("reset_mem_addr",  {2'd0, bus_if.mem_addr},    32'd0);
        check("reset_mem_wdata", bus_if.mem_wdata,           32'd0);
        check("reset_mem_be",    {28'd0, bus_if.mem_be},     32'd0);
        check("reset_busywait",  {31'd0, busywait},          32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Directed cases with hand-computed results
        do_op(4'b1010, 3'b000, 32'h0000_0100, 32'd0, 3, 32'hDEAD_BEEF, 1'b0);
        check("lit_lw", load_data_out, 32'hDEAD_BEEF);
        do_op(4'b1000, 3'b000, 32'h0000_0103, 32'd0, 1, 32'h80FF_0000, 1'b0);
        check("lit_lb", load_data_out, 32'hFFFF_FF80);
        do_op(4'b1100, 3'b000, 32'h0000_0103, 32'd0, 2, 32'h80FF_0000, 1'b0);
        check("lit_lbu", load_data_out, 32'h0000_0080);
        do_op(4'b1001, 3'b000, 32'h0000_0102, 32'd0, 1, 32'h80FF_0000, 1'b0);
        check("lit_lh", load_data_out, 32'hFFFF_80FF);
        do_op(4'b0000, 3'b101, 32'h0000_0102, 32'h1234_ABCD, 1, 32'h5555_5555, 1'b0);
        check("lit_sh_ld_kept", load_data_out, 32'hFFFF_80FF);
        check("lit_sh_be",      {28'd0, bus_if.mem_be}, 32'h0000_000C);
        check("lit_sh_wdata",   bus_if.mem_wdata, 32'hABCD_ABCD);
        do_op(4'b1010, 3'b000, 32'h0000_0101, 32'd0, 1, 32'd0, 1'b0);
        do_op(4'b0000, 3'b101, 32'h0000_0003, 32'd0, 1, 32'd0, 1'b0);
        do_op(4'b1011, 3'b000, 32'h0000_0100, 32'd0, 1, 32'd0, 1'b0);
        do_op(4'b1010, 3'b000, 32'h0000_0104, 32'd0, 6, 32'd0, 1'b0);
        check("lit_timeout_ld", load_data_out, 32'd0);
        do_op(4'b1010, 3'b000, 32'h0000_0108, 32'd0, 1, 32'h1122_3344, 1'b0);
        check("lit_after_to", load_data_out, 32'h1122_3344);
        reset_mid_access();
        do_op(4'b0000, 3'b110, 32'h0000_0010, 32'hCAFE_F00D, 2, 32'd0, 1'b1);
        check("lit_sw_ld_kept", load_data_out, 32'd0);
        do_op(4'b0000, 3'b000, 32'h0000_0000, 32'd0, 1, 32'd0, 1'b1);

        // Randomized ops; addresses are often forced aligned to exercise accesses
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            do_op(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), a, $urandom,
                  int'($urandom_range(1, 6)), $urandom, 1'($urandom_range(0, 1)));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage data-memory access controller for the RV32IM pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes that register's memory-control, address (ALU result) and store-data fields. It drives a word-addressed req/ack data-memory port and returns busywait to stall the pipeline. It also provides sign/zero-extended load data to the MEM/WB path.

Parameters:
ACK_TIMEOUT, 64, max ACCESS cycles without mem_ack before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
mem_read_in  in  4  bit3=load enable; bits[2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
mem_write_in  in  3  bit2=store enable; bits[1:0] (00 SB, 01 SH, 10 SW)
addr_in  in  32  byte address (EX/MEM ALU result)
store_data_in  in  32  store operand (EX/MEM read_data2)
busywait  out  1  stall request to all upstream pipeline registers
load_data_out  out  32  extended load result
misaligned_out  out  1  current op is misaligned (combinational)
bus_error_out  out  1  timeout abort flag
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read
mem_addr  out  30  word address (addr_in[31:2])
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_rdata  in  32  memory read word
mem_ack  in  1  memory completion, 1-cycle pulse

Behaviour:
- Reset (async, immediate): state=IDLE; timeout counter=0; load_data_out=0; bus_error_out=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_be=0.
- Valid op:
  - A load is valid when bit3=1 and funct3 is one of the five listed codes.
  - A store is valid when bit2=1 and bits[1:0]≠11.
  - Any other encoding is a no-op: no request and no busywait.
- Load and store both valid: the load is performed and the store is ignored.
- Misaligned:
  - Halfword ops with addr[0]=1 are misaligned.
  - Word ops with addr[1:0]≠00 are misaligned.
  - A misaligned op gives misaligned_out=1, busywait=0, and no request. misaligned_out is 0 otherwise.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: when a valid, aligned op is present, busywait=1 combinationally in the same cycle. On the next edge the unit registers mem_addr, mem_we, mem_be and mem_wdata, sets mem_req=1, clears the counter, and goes to ACCESS.
  - ACCESS: busywait=1 and mem_req=1. The counter increments each cycle.
    - mem_ack=1: next edge captures the extended load (loads only; stores leave load_data_out unchanged), clears mem_req and goes to DONE.
    - Counter reaches ACK_TIMEOUT-1 without ack: next edge clears mem_req, sets load_data_out=0 and bus_error_out=1, and goes to DONE.
    - Ack and timeout in the same cycle: ack wins.
  - DONE: lasts exactly one cycle with busywait=0, so the EX/MEM register advances on this edge. The next edge returns to IDLE and clears bus_error_out. The op still present during DONE is not re-issued.
- Latency: for an ack arriving in ACCESS cycle n (n≥1), busywait is high for n+1 cycles. Minimum stall is 2 cycles.
- mem_ack outside ACCESS is ignored.
- Store lanes:
  - SB: mem_be = 0001<<addr[1:0]; wdata = {4{store_data_in[7:0]}}.
  - SH: mem_be = 0011<<addr[1:0]; wdata = {2{store_data_in[15:0]}}.
  - SW: mem_be = 1111; wdata = store_data_in.
- Loads: mem_be=1111 and mem_we=0. The byte/half is selected from mem_rdata by the registered addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- load_data_out holds its value until the next load completes or a timeout occurs.
- Reset mid-ACCESS: the request is abandoned immediately. The memory must tolerate the dropped request.

Test Plan:
- LW at 0x100, ack in 3rd ACCESS cycle with rdata 0xDEADBEEF -> mem_addr=0x40, busywait high 4 cycles, load_data_out=0xDEADBEEF in DONE, busywait=0 in DONE.
- LB at 0x103, rdata 0x80FF0000 -> load_data_out=0xFFFFFF80. Repeat as LBU -> 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SH at 0x102, store_data 0x1234ABCD, immediate ack -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, busywait high 2 cycles, load_data_out unchanged.
- LW at 0x101, then SH at 0x003 -> misaligned_out=1, busywait=0, mem_req never asserted. Invalid mem_read_in=1011 -> no request, no flag.
- ACK_TIMEOUT=4, no ack on LW -> mem_req high exactly 4 cycles; DONE with bus_error_out=1 and load_data_out=0; next LW with ack proceeds normally and bus_error_out=0.
- rst pulsed in 2nd ACCESS cycle -> mem_req, busywait and outputs go to 0 without waiting for an edge. A following SW with ack completes normally; a stray mem_ack in IDLE has no effect.
